// File: rtl/adc_spi_responder.sv
// SPI peripheral emulating one ADC channel: holds a sample from a producer and
// shifts it out MSB-first on CIPO under control of a CPOL=0 SPI controller.
module adc_spi_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_clk_in,
  output logic                  chip_data_out,
  output logic                  frame_done_out,
  output logic                  frame_abort_out,
  output logic                  underrun_out,
  output logic                  overrun_out,
  output logic [15:0]           frame_count_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] flush;
  logic                   cs_prev;
  logic                   dclk_prev;
  logic                   cs_s;
  logic                   dclk_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   dclk_rise;
  logic                   dclk_fall;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   full_q, full_d;
  logic                   armed_q, armed_d;
  logic [15:0]            count_d;
  logic                   data_d;
  logic                   done_d;
  logic                   abort_d;
  logic                   underrun_d;
  logic                   overrun_d;
  logic                   frame_start;

  // The flush vector marks when the CS chain holds a real pin sample rather than
  // its reset value, so a CS held low through reset cannot arm a frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cs_sync   <= '1;
      dclk_sync <= '0;
      flush     <= '0;
      cs_prev   <= 1'b1;
      dclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_sel_in};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], chip_clk_in};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      cs_prev   <= cs_s;
      dclk_prev <= dclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dclk_s    = dclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign dclk_rise = dclk_s & ~dclk_prev;
  assign dclk_fall = ~dclk_s & dclk_prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      hold_q          <= '0;
      bit_cnt_q       <= '0;
      full_q          <= 1'b0;
      armed_q         <= 1'b0;
      chip_data_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_abort_out <= 1'b0;
      underrun_out    <= 1'b0;
      overrun_out     <= 1'b0;
      frame_count_out <= '0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      hold_q          <= hold_d;
      bit_cnt_q       <= bit_cnt_d;
      full_q          <= full_d;
      armed_q         <= armed_d;
      chip_data_out   <= data_d;
      frame_done_out  <= done_d;
      frame_abort_out <= abort_d;
      underrun_out    <= underrun_d;
      overrun_out     <= overrun_d;
      frame_count_out <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    bit_cnt_d   = bit_cnt_q;
    full_d      = full_q;
    armed_d     = armed_q;
    count_d     = frame_count_out;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    frame_start = 1'b0;

    if (flush[SYNC_STAGES-1] && cs_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          frame_start = 1'b1;
          if (full_q) begin
            shift_d = hold_q;
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
          full_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // CS rise wins over any DCLK edge seen in the same cycle.
        if (cs_rise) begin
          if (bit_cnt_q == FULL_CNT) begin
            done_d  = 1'b1;
            count_d = frame_count_out + 16'd1;
          end else begin
            abort_d = 1'b1;
          end
          shift_d = '0;
          state_d = IDLE;
        end else begin
          if (dclk_rise && (bit_cnt_q != FULL_CNT)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (dclk_fall) begin
            if (bit_cnt_q < FULL_CNT) begin
              shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              shift_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A sample arriving with the frame start is not an overrun: the old one is being sent.
    if (sample_valid_in) begin
      hold_d = sample_in;
      full_d = 1'b1;
      if (full_q && !frame_start) begin
        overrun_d = 1'b1;
      end
    end

    data_d = (state_q == SHIFT) ? shift_q[DATA_WIDTH-1] : 1'b0;
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed testbench for adc_spi_responder: acts as the SPI controller and sample producer.
module tb_adc_spi_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid_in = 1'b0;
  logic        chip_sel_in = 1'b1;
  logic        chip_clk_in = 1'b0;
  logic        chip_data_out;
  logic        frame_done_out;
  logic        frame_abort_out;
  logic        underrun_out;
  logic        overrun_out;
  logic [15:0] frame_count_out;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int underrun_cnt = 0;
  int overrun_cnt = 0;

  adc_spi_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .chip_sel_in     (chip_sel_in),
    .chip_clk_in     (chip_clk_in),
    .chip_data_out   (chip_data_out),
    .frame_done_out  (frame_done_out),
    .frame_abort_out (frame_abort_out),
    .underrun_out    (underrun_out),
    .overrun_out     (overrun_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    #1;
    if (frame_done_out)  done_cnt++;
    if (frame_abort_out) abort_cnt++;
    if (underrun_out)    underrun_cnt++;
    if (overrun_out)     overrun_cnt++;
  end

  task automatic load_sample(input logic [15:0] value);
    @(negedge clk_in);
    sample_in       = value;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  // Controller frame: DCLK low/high 5 cycles each, data captured at each DCLK rise.
  task automatic spi_frame(input int n_clks, output logic [31:0] captured);
    captured = '0;
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    repeat (6) @(negedge clk_in);
    for (int i = 0; i < n_clks; i++) begin
      chip_clk_in = 1'b1;
      captured    = {captured[30:0], chip_data_out};
      repeat (5) @(negedge clk_in);
      chip_clk_in = 1'b0;
      repeat (5) @(negedge clk_in);
    end
    chip_sel_in = 1'b1;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    tests_run++;
    if (chip_data_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %b expected 0", chip_data_out);
    end
    tests_run++;
    if (frame_count_out !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", frame_count_out);
    end
    tests_run++;
    if ({frame_done_out, frame_abort_out, underrun_out, overrun_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_pulses: got %b expected 0000",
               {frame_done_out, frame_abort_out, underrun_out, overrun_out});
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] cap;
    int d0;
    d0 = done_cnt;
    load_sample(16'hA5C3);
    spi_frame(16, cap);
    tests_run++;
    if (cap[15:0] !== 16'hA5C3) begin
      tests_failed++;
      $display("[TB] FAIL basic_data: got %h expected a5c3", cap[15:0]);
    end
    tests_run++;
    if (done_cnt - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: got %0d pulses expected 1", done_cnt - d0);
    end
    tests_run++;
    if (frame_count_out !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d expected 1", frame_count_out);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] cap;
    int d0, u0;
    d0 = done_cnt;
    u0 = underrun_cnt;
    spi_frame(16, cap);
    tests_run++;
    if (underrun_cnt - u0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL underrun_pulse: got %0d pulses expected 1", underrun_cnt - u0);
    end
    tests_run++;
    if (cap[15:0] !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL underrun_data: got %h expected 0000", cap[15:0]);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || frame_count_out !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL underrun_done: got %0d pulses count %0d expected 1 and 2",
               done_cnt - d0, frame_count_out);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] cap;
    int o0;
    o0 = overrun_cnt;
    load_sample(16'h1111);
    tests_run++;
    if (overrun_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overrun_first: got %b expected 0", overrun_out);
    end
    load_sample(16'h2222);
    tests_run++;
    if (overrun_out !== 1'b1 || overrun_cnt - o0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_pulse: got %b (%0d pulses) expected 1 (1 pulse)",
               overrun_out, overrun_cnt - o0);
    end
    spi_frame(16, cap);
    tests_run++;
    if (cap[15:0] !== 16'h2222 || frame_count_out !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL overrun_data: got %h count %0d expected 2222 and 3",
               cap[15:0], frame_count_out);
    end
  endtask

  task automatic test_abort_recovery();
    logic [31:0] cap;
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    load_sample(16'hFFFF);
    spi_frame(7, cap);
    tests_run++;
    if (abort_cnt - a0 != 1 || done_cnt - d0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_pulse: got abort %0d done %0d expected 1 and 0",
               abort_cnt - a0, done_cnt - d0);
    end
    tests_run++;
    if (cap[6:0] !== 7'h7F || frame_count_out !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL abort_partial: got %h count %0d expected 7f and 3",
               cap[6:0], frame_count_out);
    end
    load_sample(16'h0F0F);
    spi_frame(16, cap);
    tests_run++;
    if (cap[15:0] !== 16'h0F0F) begin
      tests_failed++;
      $display("[TB] FAIL recovery_data: got %h expected 0f0f", cap[15:0]);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || frame_count_out !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL recovery_done: got %0d pulses count %0d expected 1 and 4",
               done_cnt - d0, frame_count_out);
    end
  endtask

  // CS fall to first CIPO bit is 4 clk_in cycles; an immediate CS rise aborts.
  task automatic test_latency();
    int a0;
    a0 = abort_cnt;
    load_sample(16'h8000);
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    repeat (3) @(negedge clk_in);
    tests_run++;
    if (chip_data_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL latency_early: got %b expected 0", chip_data_out);
    end
    @(negedge clk_in);
    tests_run++;
    if (chip_data_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_first_bit: got %b expected 1", chip_data_out);
    end
    repeat (2) @(negedge clk_in);
    chip_sel_in = 1'b1;
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (abort_cnt - a0 != 1 || chip_data_out !== 1'b0 || frame_count_out !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL latency_abort: got abort %0d data %b count %0d expected 1, 0, 4",
               abort_cnt - a0, chip_data_out, frame_count_out);
    end
  endtask

  task automatic test_overlong();
    logic [31:0] cap;
    int d0;
    d0 = done_cnt;
    load_sample(16'h8001);
    spi_frame(20, cap);
    tests_run++;
    if (cap[19:0] !== 20'h80010) begin
      tests_failed++;
      $display("[TB] FAIL overlong_data: got %h expected 80010", cap[19:0]);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || frame_count_out !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL overlong_done: got %0d pulses count %0d expected 1 and 5",
               done_cnt - d0, frame_count_out);
    end
  endtask

  task automatic test_reset_cs_low();
    logic [31:0] cap;
    int d0, a0, u0;
    int bad_data;
    bad_data = 0;
    load_sample(16'hBEEF);
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    repeat (6) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      chip_clk_in = 1'b1;
      repeat (5) @(negedge clk_in);
      chip_clk_in = 1'b0;
      repeat (5) @(negedge clk_in);
    end
    d0 = done_cnt;
    a0 = abort_cnt;
    u0 = underrun_cnt;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10 || i == 20) chip_clk_in = 1'b1;
      if (i == 15 || i == 25) chip_clk_in = 1'b0;
      @(negedge clk_in);
      if (chip_data_out !== 1'b0) bad_data++;
    end
    tests_run++;
    if (done_cnt != d0 || abort_cnt != a0 || underrun_cnt != u0) begin
      tests_failed++;
      $display("[TB] FAIL rst_cs_low_pulses: got done %0d abort %0d underrun %0d expected 0 each",
               done_cnt - d0, abort_cnt - a0, underrun_cnt - u0);
    end
    tests_run++;
    if (bad_data != 0) begin
      tests_failed++;
      $display("[TB] FAIL rst_cs_low_data: got %0d cycles with data 1 expected 0", bad_data);
    end
    tests_run++;
    if (frame_count_out !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_cs_low_count: got %0d expected 0", frame_count_out);
    end
    load_sample(16'h1234);
    @(negedge clk_in);
    chip_sel_in = 1'b1;
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (underrun_cnt != u0 || abort_cnt != a0) begin
      tests_failed++;
      $display("[TB] FAIL rst_cs_high_pulses: got underrun %0d abort %0d expected 0 each",
               underrun_cnt - u0, abort_cnt - a0);
    end
    spi_frame(16, cap);
    tests_run++;
    if (cap[15:0] !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL rst_recovery_data: got %h expected 1234", cap[15:0]);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || frame_count_out !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL rst_recovery_done: got %0d pulses count %0d expected 1 and 1",
               done_cnt - d0, frame_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_overrun();
    test_abort_recovery();
    test_latency();
    test_overlong();
    test_reset_cs_low();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

SPI peripheral that answers the sonar receive chain's SPI controller, emulating one ADC channel. It takes samples from a producer (test pattern, recorded echo data, or a second FPGA's digitizer path) and serializes them MSB-first on `chip_data_out` in response to the controller's chip-select and data clock. It sits at the far end of the `chip_sel` / `chip_clk` / `chip_data` link. It closes the receive loop for in-system and bench testing without a physical ADC.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per SPI frame; matches the controller's `DATA_WIDTH`.
- `SYNC_STAGES`, 2: flip-flop stages on each of `chip_sel_in` and `chip_clk_in`; minimum 2.

Ports:
- `clk_in`, input, 1: system clock (100 MHz). Single clock domain.
- `rst_in`, input, 1: reset, synchronous, active-high.
- `sample_in`, input, DATA_WIDTH: next sample to transmit.
- `sample_valid_in`, input, 1: single-cycle strobe that loads `sample_in` into the holding register.
- `chip_sel_in`, input, 1: controller CS, active-low, asynchronous to `clk_in`.
- `chip_clk_in`, input, 1: controller data clock, idle-low (CPOL=0), asynchronous.
- `chip_data_out`, input/output direction output, 1: serial data (CIPO), registered.
- `frame_done_out`, output, 1: 1-cycle pulse when a full DATA_WIDTH-bit frame ends.
- `frame_abort_out`, output, 1: 1-cycle pulse when CS deasserts before DATA_WIDTH rising edges.
- `underrun_out`, output, 1: 1-cycle pulse when a frame starts with the holding register empty.
- `overrun_out`, output, 1: 1-cycle pulse when `sample_valid_in` overwrites an unsent held sample.
- `frame_count_out`, output, 16: count of completed frames; wraps at 2^16.

## Operation
Input conditioning:
- `chip_sel_in` and `chip_clk_in` each pass through SYNC_STAGES flip-flops, then one edge-detect register.
- CS synchronizer chain resets to 1. DCLK synchronizer chain resets to 0.
- `armed` flag: cleared by reset; set whenever synced CS = 1. A CS fall is honoured only while `armed` = 1. A CS held low through reset therefore never starts a frame.

Holding register:
- `sample_valid_in` writes `sample_in` and sets `full`.
- If `full` is already 1 when `sample_valid_in` arrives, the old value is overwritten and `overrun_out` pulses.

State machine:
- **IDLE**
  - `chip_data_out` = 0.
  - On an honoured synced CS fall:
    - Shift register ← holding register if `full`. Otherwise shift register ← 0 and `underrun_out` pulses.
    - `full` ← 0.
    - `bit_cnt` ← 0.
    - `chip_data_out` ← shift register MSB.
    - Go to SHIFT.
  - If `sample_valid_in` arrives in the same cycle as the frame start, the old holding content goes to the shift register, the new sample is stored, and `full` = 1.
- **SHIFT**
  - Synced DCLK rise: `bit_cnt` ← `bit_cnt` + 1, saturating at DATA_WIDTH.
  - Synced DCLK fall with `bit_cnt` < DATA_WIDTH: shift left by one, fill with 0, drive the new MSB.
  - Falls after DATA_WIDTH rises drive 0.
  - Synced CS rise:
    - If `bit_cnt` == DATA_WIDTH: `frame_done_out` pulses and `frame_count_out` increments.
    - Otherwise: `frame_abort_out` pulses.
    - In both cases `chip_data_out` ← 0 and go to IDLE.
  - CS rise takes priority over a DCLK edge detected in the same cycle; the DCLK edge is ignored.

## Timing
- Reset values: state IDLE, `chip_data_out` 0, all pulse outputs 0, `frame_count_out` 0, `full` 0, `armed` 0, shift register 0, `bit_cnt` 0.
- Pin-edge to internal-event latency is SYNC_STAGES + 1 cycles. `chip_data_out` updates 1 cycle later, i.e. SYNC_STAGES + 2 cycles after the pin edge (4 cycles at default).
- Requirement on the controller: DCLK low phase ≥ SYNC_STAGES + 3 `clk_in` cycles, and the first DCLK rise ≥ SYNC_STAGES + 3 cycles after CS fall. This ensures data is stable at the controller's rising-edge sample point.
- Requirement on the controller: DCLK high phase ≥ SYNC_STAGES + 1 cycles, and CS high ≥ SYNC_STAGES + 1 cycles between frames.
- Frame status pulses (`frame_done_out` / `frame_abort_out`) assert SYNC_STAGES + 1 cycles after the CS pin rise.
- `underrun_out` asserts in the same cycle that SHIFT is entered.
- `overrun_out` asserts in the cycle `sample_valid_in` is sampled.
- Reset mid-frame:
  - Immediate return to IDLE with `chip_data_out` = 0 and no status pulse.
  - The next frame requires CS to be observed high, then fall.

## Test plan
- **Basic frame.** Load 0xA5C3, then run a 16-bit frame with DCLK period 10. Required: the controller captures 0xA5C3, `frame_done_out` pulses once, and `frame_count_out` = 1.
- **Underrun.** Start a frame with no sample loaded. Required: `underrun_out` pulses on frame start, 16 zero bits are shifted, and `frame_done_out` pulses.
- **Overrun.** Load 0x1111, then 0x2222 before any frame. Required: `overrun_out` pulses on the second load, and the next frame delivers 0x2222.
- **Abort and recovery.** Load 0xFFFF, raise CS after 7 DCLK rises, then run a full frame carrying 0x0F0F. Required: `frame_abort_out` pulses once with no `frame_done_out`, and the following frame returns 0x0F0F.
- **Overlong frame.** Run 20 DCLK cycles with sample 0x8001. Required: bits 17–20 read 0, `frame_done_out` pulses, and `frame_count_out` increments by 1.
- **Reset with CS low.** Assert `rst_in` mid-frame while holding CS low for 30 cycles after reset. Required: no frame starts and no pulses occur; after CS goes high then low, a normal frame completes.
